// File: rtl/mips_check_pkg.sv
// rtl/mips_check_pkg.sv - shared state encoding and default checker constants
package mips_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TMO
   } chk_state_t;

   localparam logic [31:0] CHK_PASS_ADDR    = 32'd84;
   localparam logic [31:0] CHK_PASS_DATA    = 32'd0;
   localparam logic [31:0] CHK_SCRATCH_ADDR = 32'd80;
   localparam int          CHK_TIMEOUT      = 1000;
   localparam int          CHK_CNT_W        = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/mips_store_checker.sv
// rtl/mips_store_checker.sv - classifies a MIPS program run as pass, fail or timeout
// by watching the data-memory write port of the core.
module mips_store_checker
   import mips_check_pkg::*;
#(
   parameter logic [31:0] PASS_ADDR      = CHK_PASS_ADDR,
   parameter logic [31:0] PASS_DATA      = CHK_PASS_DATA,
   parameter logic [31:0] SCRATCH_ADDR   = CHK_SCRATCH_ADDR,
   parameter int          TIMEOUT_CYCLES = CHK_TIMEOUT,
   parameter int          CNT_W          = CHK_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             memwrite,
   input  logic [31:0]      dataadr,
   input  logic [31:0]      writedata,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] store_count,
   output logic [CNT_W-1:0] cycle_count,
   output logic [31:0]      err_addr,
   output logic [31:0]      err_data
);

   localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   chk_state_t  r_state;
   chk_state_t  w_state_nxt;
   logic [31:0] r_err_addr;
   logic [31:0] r_err_data;

   logic w_run;
   logic w_arm;
   logic w_pass_hit;
   logic w_scratch_hit;
   logic w_stray;
   logic w_tmo_hit;

   assign w_run = (r_state == ST_RUN);
   // start re-arms from IDLE and from every terminal state, never from RUN
   assign w_arm = start && !w_run;

   // Pass match is tested first so it wins even when PASS_ADDR == SCRATCH_ADDR
   assign w_pass_hit    = memwrite && (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
   assign w_scratch_hit = memwrite && !w_pass_hit && (dataadr == SCRATCH_ADDR);
   assign w_stray       = memwrite && !w_pass_hit && !w_scratch_hit;
   assign w_tmo_hit     = !memwrite && (cycle_count == LP_TMO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_pass_hit) begin
               w_state_nxt = ST_PASS;
            end else if (w_scratch_hit) begin
               w_state_nxt = ST_RUN;
            end else if (w_stray) begin
               w_state_nxt = ST_FAIL;
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_TMO;
            end
         end
         default: begin
            if (start) begin
               w_state_nxt = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_addr <= '0;
         r_err_data <= '0;
      end else if (w_arm) begin
         r_err_addr <= '0;
         r_err_data <= '0;
      end else if (w_run && w_stray) begin
         r_err_addr <= dataadr;
         r_err_data <= writedata;
      end
   end

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (w_arm),
      .i_inc   (w_run),
      .o_count (cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_store_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .i_clr   (w_arm),
      .i_inc   (w_run && w_scratch_hit),
      .o_count (store_count)
   );

   assign pass     = (r_state == ST_PASS);
   assign fail     = (r_state == ST_FAIL);
   assign timeout  = (r_state == ST_TMO);
   assign done     = pass || fail || timeout;
   assign err_addr = r_err_addr;
   assign err_data = r_err_data;

endmodule

// File: tb/tb_mips_store_checker.sv
// tb/tb_mips_store_checker.sv - directed and randomized bench for mips_store_checker
module tb_mips_store_checker;

   localparam int T     = 8;
   localparam int CW    = 16;
   localparam int MAXC  = 65535;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_PASS = 2;
   localparam int M_FAIL = 3;
   localparam int M_TMO  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          memwrite = 1'b0;
   logic [31:0]   dataadr = '0;
   logic [31:0]   writedata = '0;
   logic          done, pass, fail, timeout;
   logic [CW-1:0] store_count, cycle_count;
   logic [31:0]   err_addr, err_data;

   int n_tests = 0;
   int n_fail  = 0;

   int          m_mode = M_IDLE;
   int          m_sc = 0;
   int          m_cc = 0;
   logic [31:0] m_ea = '0;
   logic [31:0] m_ed = '0;

   mips_store_checker #(
      .PASS_ADDR      (32'd84),
      .PASS_DATA      (32'd0),
      .SCRATCH_ADDR   (32'd80),
      .TIMEOUT_CYCLES (T),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .memwrite    (memwrite),
      .dataadr     (dataadr),
      .writedata   (writedata),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .store_count (store_count),
      .cycle_count (cycle_count),
      .err_addr    (err_addr),
      .err_data    (err_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_sc   = 0;
      m_cc   = 0;
      m_ea   = '0;
      m_ed   = '0;
   endtask

   task automatic model_edge(input logic st, input logic mw, input logic [31:0] a, input logic [31:0] d);
      int old_cc;
      old_cc = m_cc;
      if (m_mode == M_RUN) begin
         m_cc = (m_cc < MAXC) ? m_cc + 1 : MAXC;
         if (mw && a == 32'd84 && d == 32'd0) begin
            m_mode = M_PASS;
         end else if (mw && a == 32'd80) begin
            m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
         end else if (mw) begin
            m_mode = M_FAIL;
            m_ea   = a;
            m_ed   = d;
         end else if (old_cc == T - 1) begin
            m_mode = M_TMO;
         end
      end else if (st) begin
         m_mode = M_RUN;
         m_sc   = 0;
         m_cc   = 0;
         m_ea   = '0;
         m_ed   = '0;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".done"},    32'(done),        32'(m_mode >= M_PASS));
      check({tag, ".pass"},    32'(pass),        32'(m_mode == M_PASS));
      check({tag, ".fail"},    32'(fail),        32'(m_mode == M_FAIL));
      check({tag, ".timeout"}, 32'(timeout),     32'(m_mode == M_TMO));
      check({tag, ".stores"},  32'(store_count), 32'(m_sc));
      check({tag, ".cycles"},  32'(cycle_count), 32'(m_cc));
      check({tag, ".eaddr"},   err_addr,         m_ea);
      check({tag, ".edata"},   err_data,         m_ed);
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later
   task automatic step(input string tag, input logic st, input logic mw,
                       input logic [31:0] a, input logic [31:0] d);
      start     = st;
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      @(posedge clk);
      model_edge(st, mw, a, d);
      #1;
      check_model(tag);
   endtask

   task automatic async_reset(input string tag);
      reset = 1'b0;
      #2;
      model_reset();
      check_model(tag);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int          pick;
      logic        r_st;
      logic        r_mw;
      logic [31:0] r_a;
      logic [31:0] r_d;

      #12;
      check_model("reset");
      reset = 1'b1;

      // normal pass
      step("np.start", 1'b1, 1'b0, 32'd0, 32'd0);
      step("np.scr", 1'b0, 1'b1, 32'd80, 32'd7);
      step("np.pass", 1'b0, 1'b1, 32'd84, 32'd0);
      check("np.pass_flag", 32'(pass), 32'd1);
      check("np.done_flag", 32'(done), 32'd1);
      check("np.store_cnt", 32'(store_count), 32'd1);
      check("np.err_addr", err_addr, 32'd0);

      // wrong pass data, then a correct pass store must not leave FAIL
      step("wd.start", 1'b1, 1'b0, 32'd0, 32'd0);
      step("wd.bad", 1'b0, 1'b1, 32'd84, 32'd5);
      check("wd.fail_flag", 32'(fail), 32'd1);
      check("wd.err_addr", err_addr, 32'd84);
      check("wd.err_data", err_data, 32'd5);
      step("wd.late", 1'b0, 1'b1, 32'd84, 32'd0);
      check("wd.still_fail", 32'(fail), 32'd1);
      check("wd.no_pass", 32'(pass), 32'd0);

      // stray address
      step("st.start", 1'b1, 1'b0, 32'd0, 32'd0);
      step("st.bad", 1'b0, 1'b1, 32'h100, 32'hDEAD);
      check("st.fail_flag", 32'(fail), 32'd1);
      check("st.err_addr", err_addr, 32'h100);
      check("st.err_data", err_data, 32'hDEAD);

      // timeout exactly T edges after entering RUN
      step("to.start", 1'b1, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < T - 1; i++) begin
         step("to.wait", 1'b0, 1'b0, 32'd0, 32'd0);
      end
      check("to.not_yet", 32'(timeout), 32'd0);
      step("to.last", 1'b0, 1'b0, 32'd0, 32'd0);
      check("to.timeout", 32'(timeout), 32'd1);
      check("to.cycles", 32'(cycle_count), 32'(T));

      // pass store on the timeout cycle wins
      step("tp.start", 1'b1, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < T - 1; i++) begin
         step("tp.wait", 1'b0, 1'b0, 32'd0, 32'd0);
      end
      step("tp.pass", 1'b0, 1'b1, 32'd84, 32'd0);
      check("tp.pass_flag", 32'(pass), 32'd1);
      check("tp.no_tmo", 32'(timeout), 32'd0);

      // asynchronous reset mid-run, then stores ignored in IDLE
      step("rs.start", 1'b1, 1'b0, 32'd0, 32'd0);
      step("rs.scr", 1'b0, 1'b1, 32'd80, 32'd1);
      async_reset("rs.async");
      check("rs.cycles0", 32'(cycle_count), 32'd0);
      check("rs.stores0", 32'(store_count), 32'd0);
      step("rs.ign", 1'b0, 1'b1, 32'h200, 32'd1);
      check("rs.idle_fail", 32'(fail), 32'd0);
      check("rs.idle_done", 32'(done), 32'd0);

      // re-arm after a pass
      step("ra.start", 1'b1, 1'b0, 32'd0, 32'd0);
      step("ra.pass", 1'b0, 1'b1, 32'd84, 32'd0);
      step("ra.rearm", 1'b1, 1'b0, 32'd0, 32'd0);
      check("ra.cycles0", 32'(cycle_count), 32'd0);
      check("ra.stores0", 32'(store_count), 32'd0);
      check("ra.done0", 32'(done), 32'd0);
      step("ra.scr", 1'b0, 1'b1, 32'd80, 32'd7);
      step("ra.pass2", 1'b0, 1'b1, 32'd84, 32'd0);
      check("ra.pass_flag", 32'(pass), 32'd1);
      check("ra.store_cnt", 32'(store_count), 32'd1);

      // randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         r_st = ($urandom_range(0, 7) == 0);
         r_mw = ($urandom_range(0, 3) == 0);
         pick = int'($urandom_range(0, 5));
         case (pick)
            0, 1, 2: r_a = 32'd80;
            3:       r_a = 32'd84;
            4:       r_a = $urandom & 32'h0000_0FFC;
            default: r_a = $urandom;
         endcase
         r_d = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom);
         step("rnd", r_st, r_mw, r_a, r_d);
         if ($urandom_range(0, 99) == 0) begin
            async_reset("rnd.rst");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_store_checker.md
# mips_store_checker

Synthesizable self-check stage downstream of the single-cycle MIPS `top`. It consumes the core's data-memory write port (`memwrite`, `dataadr`, `writedata`) every cycle and classifies the program run as pass, fail or timeout. Pass is a store of `PASS_DATA` to `PASS_ADDR`; stores to `SCRATCH_ADDR` are permitted and counted. It replaces negedge checking in benches and allows on-board status LEDs.

## Interface
- `PASS_ADDR`, 84: address whose store ends the run.
- `PASS_DATA`, 0: data required at `PASS_ADDR` for pass.
- `SCRATCH_ADDR`, 80: address where stores are allowed and counted.
- `TIMEOUT_CYCLES`, 1000: cycles in RUN before timeout; must be ≥ 1.
- `CNT_W`, 16: width of both counters.
- `clk` in 1: rising-edge clock, same clock as the core.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: arms the checker; single-cycle pulse or level.
- `memwrite` in 1: core store strobe.
- `dataadr` in 32: store address.
- `writedata` in 32: store data.
- `done` out 1: high in PASS, FAIL or TMO.
- `pass` out 1: high in PASS.
- `fail` out 1: high in FAIL.
- `timeout` out 1: high in TMO.
- `store_count` out CNT_W: number of scratch stores accepted this run.
- `cycle_count` out CNT_W: number of cycles spent in RUN.
- `err_addr` out 32: address of the offending store.
- `err_data` out 32: data of the offending store.

## Operation
- States: IDLE, RUN, PASS, FAIL, TMO. Reset state is IDLE.
- Reset values: all status outputs 0; counters 0; `err_addr` and `err_data` 0.
- IDLE:
  - `start` = 1 → RUN, clear counters and error capture.
  - Store strobes are ignored.
- RUN, evaluated at each rising edge, in this priority order:
  1. `memwrite` and `dataadr == PASS_ADDR` and `writedata == PASS_DATA` → PASS.
  2. `memwrite` and `dataadr == SCRATCH_ADDR` → stay in RUN, `store_count` += 1.
  3. Any other `memwrite` → FAIL. This includes `PASS_ADDR` with wrong data. Capture `dataadr` into `err_addr` and `writedata` into `err_data`.
  4. No store and `cycle_count == TIMEOUT_CYCLES-1` → TMO.
  5. Otherwise stay in RUN.
- `cycle_count` increments on every RUN cycle, including the terminal one.
- A store event on the timeout cycle wins over the timeout.
- Both counters saturate at all-ones and never wrap.
- Terminal states (PASS, FAIL, TMO):
  - Hold all outputs.
  - Ignore stores.
  - `start` = 1 → RUN with counters and error capture cleared (re-arm).
- `start` while in RUN is ignored.
- If `PASS_ADDR == SCRATCH_ADDR`, rule 1 takes priority.
- Reset asserted at any time, including mid-RUN, forces IDLE and reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- A store sampled at edge N appears on `done`, status flags, counters and the error capture after edge N.
- `start` sampled at edge N → in RUN after N, with `cycle_count` = 0. The first store considered is the one sampled at edge N+1.
- Timeout with no stores: `timeout` rises exactly `TIMEOUT_CYCLES` edges after entering RUN.
- Reset release is asynchronous to the design; the first evaluated edge is the first edge after release. Integrators synchronize `reset` deassertion externally.

## Structure
- Package `mips_check_pkg` holds:
  - `chk_state_t` enum (IDLE, RUN, PASS, FAIL, TMO).
  - Default constants `CHK_PASS_ADDR`, `CHK_PASS_DATA`, `CHK_SCRATCH_ADDR`, `CHK_TIMEOUT`.
- One sub-module, `sat_counter`:
  - Parameterized width, with `clr`, `inc` and async active-low reset.
  - Instantiated twice, once per counter.
- The FSM and error capture live in the top module.

## Test plan
- **Normal pass:** `start`; one scratch store (80, 7); then store (84, 0) → after that edge `done` = 1, `pass` = 1, `store_count` = 1, `err_addr` = 0.
- **Wrong pass data:** store (84, 5) → `fail` = 1, `err_addr` = 84, `err_data` = 5; a later store (84, 0) leaves the state at FAIL.
- **Stray address:** store (0x100, 0xDEAD) → `fail` = 1, `err_addr` = 0x100, `err_data` = 0xDEAD.
- **Timeout:** `TIMEOUT_CYCLES` = 8, no stores → `timeout` = 1 after exactly 8 edges, `cycle_count` = 8. A second run with store (84, 0) on the 8th RUN cycle → `pass` = 1, `timeout` = 0.
- **Reset and re-arm:** assert `reset` = 0 mid-RUN between clock edges → outputs clear immediately, state IDLE, stores ignored until `start`. After a PASS, pulse `start` → counters 0 and a new run behaves as in the normal-pass scenario.
